// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size derivations, GF(2^8) xtime, the key
// schedule FSM states and the forward S-box table.
package aes_pkg;

  localparam int AES128_BITS = 128;
  localparam int AES192_BITS = 192;
  localparam int AES256_BITS = 256;

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return nk_of(key_bits) + 6;
  endfunction

  function automatic int nw_of(input int key_bits);
    return 4 * (nr_of(key_bits) + 1);
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Entry 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: four parallel S-box byte substitutions on one
// 32-bit word. Shared between the key schedule and the cipher round.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  assign sub[31:24] = sbox(word[31:24]);
  assign sub[23:16] = sbox(word[23:16]);
  assign sub[15:8]  = sbox(word[15:8]);
  assign sub[7:0]   = sbox(word[7:0]);

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock into
// a register buffer, with a registered indexed round-key read port.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  input  logic [3:0]          rk_idx,
  output logic [127:0]        rk_out
);

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);
  localparam int IW = 6;

  if (KEY_BITS != AES128_BITS && KEY_BITS != AES192_BITS &&
      KEY_BITS != AES256_BITS) begin : g_bad_key_bits
    $error("aes_key_schedule_seq: KEY_BITS must be 128, 192 or 256");
  end

  state_t          state;
  logic [IW-1:0]   i_cnt;
  logic [2:0]      wrap;
  logic [7:0]      rcon;
  logic [31:0]     w [NW];

  logic [31:0]     t_word;
  logic [31:0]     k_word;
  logic [31:0]     sub_in;
  logic [31:0]     sub_out;
  logic [31:0]     next_word;

  // Single SubWord datapath: RotWord is applied in front of it only on the
  // words that start a new key-length group.
  // NOTE: every always_comb output is assigned a default first so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    t_word    = w[i_cnt - IW'(1)];
    k_word    = w[i_cnt - IW'(NK)];
    sub_in    = t_word;
    next_word = k_word ^ t_word;
    if (wrap == 3'd0) begin
      sub_in    = {t_word[23:0], t_word[31:24]};
      next_word = k_word ^ sub_out ^ {rcon, 24'h0};
    end else if (NK == 8 && wrap == 3'd4) begin
      next_word = k_word ^ sub_out;
    end
  end

  aes_subword u_subword (
    .word (sub_in),
    .sub  (sub_out)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      i_cnt      <= '0;
      wrap       <= '0;
      rcon       <= '0;
      // NOTE: the schedule buffer is reset so a partially expanded key can
      // never be observed after a reset.
      for (int n = 0; n < NW; n++) w[n] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int n = 0; n < NK; n++) w[n] <= key_in[KEY_BITS-1-32*n -: 32];
            i_cnt      <= IW'(NK);
            wrap       <= '0;
            rcon       <= 8'h01;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          w[i_cnt] <= next_word;
          i_cnt    <= i_cnt + IW'(1);
          wrap     <= (wrap == 3'(NK - 1)) ? 3'd0 : wrap + 3'd1;
          if (wrap == 3'd0) rcon <= xtime(rcon);
          if (i_cnt == IW'(NW - 1)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Out-of-range indices are clamped to 0 before addressing the buffer and
  // then forced to a zero result, keeping every buffer access in bounds.
  logic          idx_ok;
  logic [IW-1:0] base;

  assign idx_ok = (rk_idx <= 4'(NR));
  assign base   = idx_ok ? {rk_idx, 2'b00} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out <= '0;
    end else if (keys_valid && idx_ok) begin
      rk_out <= {w[base], w[base + IW'(1)], w[base + IW'(2)], w[base + IW'(3)]};
    end else begin
      rk_out <= '0;
    end
  end

endmodule
